// File: rtl/sgmii_an_rx_monitor_if.sv
// Bundles the decoded receive character stream and the auto-negotiation status
// outputs of the SGMII receive-side AN monitor.
interface sgmii_an_rx_monitor_if;
    logic        an_enable;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_is_k;
    logic        rx_code_err;
    logic [2:0]  an_state;
    logic [15:0] partner_cfg;
    logic        partner_cfg_valid;
    logic        tx_ack_req;
    logic        link_ok;
    logic        restart_pulse;

    modport master (
        output an_enable, rx_valid, rx_data, rx_is_k, rx_code_err,
        input  an_state, partner_cfg, partner_cfg_valid, tx_ack_req, link_ok, restart_pulse
    );

    modport slave (
        input  an_enable, rx_valid, rx_data, rx_is_k, rx_code_err,
        output an_state, partner_cfg, partner_cfg_valid, tx_ack_req, link_ok, restart_pulse
    );
endinterface

// File: rtl/sgmii_an_rx_monitor.sv
// Receive side of SGMII auto-negotiation: parses /C/ and /I/ ordered sets from the
// decoded character stream, tracks ability/ack matches and walks the AN state machine.
module sgmii_an_rx_monitor #(
    parameter int unsigned MATCH_COUNT       = 3,
    parameter int unsigned IDLE_COUNT        = 3,
    parameter int unsigned LINK_TIMER_CYCLES = 200000,
    parameter int unsigned TIMER_W           = 18
) (
    input logic                   i_sgmii_clk_in,
    input logic                   i_reset_n,
    sgmii_an_rx_monitor_if.slave  bus
);
    localparam int unsigned CntW  = $clog2(MATCH_COUNT + 1);
    localparam int unsigned IdleW = $clog2(IDLE_COUNT + 1);
    localparam logic [CntW-1:0]    MatchMax = CntW'(MATCH_COUNT);
    localparam logic [IdleW-1:0]   IdleMax  = IdleW'(IDLE_COUNT);
    localparam logic [TIMER_W-1:0] TimerMax = TIMER_W'(LINK_TIMER_CYCLES - 1);

    typedef enum logic [1:0] {PHunt, PType, PCfgLo, PCfgHi} parse_e;
    typedef enum logic [2:0] {
        AnRestart     = 3'd0,
        AbilityDetect = 3'd1,
        AckDetect     = 3'd2,
        CompleteAck   = 3'd3,
        IdleDetect    = 3'd4,
        LinkOk        = 3'd5
    } an_state_e;

    parse_e           r_pstate;
    logic [7:0]       r_cfg_lo;
    logic [15:0]      r_cfg_word;
    logic             r_cfg_valid;
    logic             r_idle_valid;
    logic             r_invalid;
    logic [15:0]      r_prev_word;
    logic             r_prev_vld;
    logic             r_word_upd;
    logic [CntW-1:0]  r_ability_cnt;
    logic [CntW-1:0]  r_ack_cnt;
    logic [IdleW-1:0] r_idle_cnt;
    logic [TIMER_W-1:0] r_timer;
    an_state_e        r_state;
    an_state_e        w_state_d;
    logic             w_latch;
    logic [15:0]      r_partner_cfg;
    logic             r_partner_cfg_valid;
    logic             r_restart_pulse;

    logic w_comma, w_cfg_id, w_idle_id, w_same, w_word_zero, w_match_partner, w_expired;

    assign w_comma   = bus.rx_is_k && (bus.rx_data == 8'hBC);
    assign w_cfg_id  = !bus.rx_is_k && (bus.rx_data == 8'hB5 || bus.rx_data == 8'h42);
    assign w_idle_id = !bus.rx_is_k && (bus.rx_data == 8'hC5 || bus.rx_data == 8'h50);

    // Ordered-set parser; all outputs are one-cycle pulses registered after the last char.
    always_ff @(posedge i_sgmii_clk_in or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_pstate     <= PHunt;
            r_cfg_lo     <= '0;
            r_cfg_word   <= '0;
            r_cfg_valid  <= 1'b0;
            r_idle_valid <= 1'b0;
            r_invalid    <= 1'b0;
        end else begin
            r_cfg_valid  <= 1'b0;
            r_idle_valid <= 1'b0;
            r_invalid    <= 1'b0;
            if (bus.rx_valid) begin
                if (bus.rx_code_err) begin
                    r_pstate  <= PHunt;
                    r_invalid <= 1'b1;
                end else if (w_comma) begin
                    r_pstate <= PType;
                end else begin
                    case (r_pstate)
                        PType: begin
                            if (w_cfg_id) begin
                                r_pstate <= PCfgLo;
                            end else begin
                                r_pstate <= PHunt;
                                if (w_idle_id) r_idle_valid <= 1'b1;
                                else           r_invalid    <= 1'b1;
                            end
                        end
                        PCfgLo: begin
                            if (bus.rx_is_k) begin
                                r_pstate  <= PHunt;
                                r_invalid <= 1'b1;
                            end else begin
                                r_cfg_lo <= bus.rx_data;
                                r_pstate <= PCfgHi;
                            end
                        end
                        PCfgHi: begin
                            r_pstate <= PHunt;
                            if (bus.rx_is_k) begin
                                r_invalid <= 1'b1;
                            end else begin
                                r_cfg_word  <= {bus.rx_data, r_cfg_lo};
                                r_cfg_valid <= 1'b1;
                            end
                        end
                        default: r_pstate <= PHunt;
                    endcase
                end
            end
        end
    end

    // Ability match ignores the ack bit; ack match only counts words carrying it.
    assign w_same = {r_cfg_word[15], r_cfg_word[13:0]} == {r_prev_word[15], r_prev_word[13:0]};

    always_ff @(posedge i_sgmii_clk_in or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_prev_word   <= '0;
            r_prev_vld    <= 1'b0;
            r_word_upd    <= 1'b0;
            r_ability_cnt <= '0;
            r_ack_cnt     <= '0;
            r_idle_cnt    <= '0;
        end else begin
            r_word_upd <= r_cfg_valid;
            if (r_cfg_valid) r_prev_word <= r_cfg_word;
            if (r_state == AnRestart || r_invalid) begin
                r_prev_vld    <= 1'b0;
                r_ability_cnt <= '0;
                r_ack_cnt     <= '0;
                r_idle_cnt    <= '0;
            end else if (r_cfg_valid) begin
                r_idle_cnt <= '0;
                if (r_cfg_word == 16'h0000) begin
                    r_prev_vld    <= 1'b0;
                    r_ability_cnt <= '0;
                    r_ack_cnt     <= '0;
                end else begin
                    r_prev_vld <= 1'b1;
                    if (r_prev_vld && w_same)
                        r_ability_cnt <= (r_ability_cnt == MatchMax) ? MatchMax
                                                                     : r_ability_cnt + 1'b1;
                    else
                        r_ability_cnt <= CntW'(1);
                    if (!r_cfg_word[14])
                        r_ack_cnt <= '0;
                    else if (r_prev_vld && r_prev_word[14] && w_same)
                        r_ack_cnt <= (r_ack_cnt == MatchMax) ? MatchMax : r_ack_cnt + 1'b1;
                    else
                        r_ack_cnt <= CntW'(1);
                end
            end else if (r_idle_valid && r_idle_cnt != IdleMax) begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end
        end
    end

    assign w_word_zero     = (r_prev_word == 16'h0000);
    assign w_match_partner = {r_prev_word[15], r_prev_word[13:0]} ==
                             {r_partner_cfg[15], r_partner_cfg[13:0]};
    assign w_expired       = (r_timer == TimerMax);

    always_comb begin
        w_state_d = r_state;
        w_latch   = 1'b0;
        unique case (r_state)
            AnRestart: w_state_d = AbilityDetect;
            AbilityDetect: begin
                if (r_word_upd && r_ability_cnt == MatchMax && !w_word_zero) begin
                    w_state_d = AckDetect;
                    w_latch   = 1'b1;
                end
            end
            AckDetect: begin
                if (r_word_upd) begin
                    if (w_word_zero || (r_prev_word[14] && !w_match_partner))
                        w_state_d = AnRestart;
                    else if (r_ack_cnt == MatchMax && w_match_partner)
                        w_state_d = CompleteAck;
                end
            end
            CompleteAck: begin
                if (r_word_upd && w_word_zero) w_state_d = AnRestart;
                else if (w_expired)            w_state_d = IdleDetect;
            end
            IdleDetect: begin
                if (r_word_upd)                                w_state_d = AnRestart;
                else if (r_idle_cnt >= IdleMax && w_expired)   w_state_d = LinkOk;
            end
            LinkOk: if (r_word_upd) w_state_d = AnRestart;
            default: w_state_d = AnRestart;
        endcase
        if (!bus.an_enable) w_state_d = AnRestart;
    end

    always_ff @(posedge i_sgmii_clk_in or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state             <= AnRestart;
            r_timer             <= '0;
            r_partner_cfg       <= '0;
            r_partner_cfg_valid <= 1'b0;
            r_restart_pulse     <= 1'b0;
        end else begin
            r_state             <= w_state_d;
            r_partner_cfg_valid <= w_latch;
            r_restart_pulse     <= (w_state_d == AnRestart) && (r_state != AnRestart);
            if (w_latch) r_partner_cfg <= {r_prev_word[15], 1'b0, r_prev_word[13:0]};
            // Timer restarts on every state change and saturates at expiry.
            if (r_state == AnRestart || w_state_d != r_state) r_timer <= '0;
            else if (!w_expired)                              r_timer <= r_timer + 1'b1;
        end
    end

    assign bus.an_state          = r_state;
    assign bus.partner_cfg       = r_partner_cfg;
    assign bus.partner_cfg_valid = r_partner_cfg_valid;
    assign bus.tx_ack_req        = (r_state == AckDetect) || (r_state == CompleteAck);
    assign bus.link_ok           = (r_state == LinkOk);
    assign bus.restart_pulse     = r_restart_pulse;
endmodule

// File: tb/tb_sgmii_an_rx_monitor.sv
// Directed bench for sgmii_an_rx_monitor: drives ordered sets and checks AN outcomes
// against hand-computed expectations (link timer shortened to 100 cycles).
module tb_sgmii_an_rx_monitor;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;
    int   pcv_cnt;

    sgmii_an_rx_monitor_if bus ();

    sgmii_an_rx_monitor #(
        .MATCH_COUNT       (3),
        .IDLE_COUNT        (3),
        .LINK_TIMER_CYCLES (100),
        .TIMER_W           (18)
    ) dut (
        .i_sgmii_clk_in (clk),
        .i_reset_n      (rst_n),
        .bus            (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bus.partner_cfg_valid) pcv_cnt++;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_char(input logic [7:0] d, input logic k, input logic err);
        bus.rx_valid    = 1'b1;
        bus.rx_data     = d;
        bus.rx_is_k     = k;
        bus.rx_code_err = err;
        tick(1);
        bus.rx_valid    = 1'b0;
        bus.rx_is_k     = 1'b0;
        bus.rx_code_err = 1'b0;
    endtask

    task automatic send_cfg(input logic [15:0] w, input logic c2);
        send_char(8'hBC, 1'b1, 1'b0);
        send_char(c2 ? 8'h42 : 8'hB5, 1'b0, 1'b0);
        send_char(w[7:0], 1'b0, 1'b0);
        send_char(w[15:8], 1'b0, 1'b0);
    endtask

    task automatic send_idle(input logic i2);
        send_char(8'hBC, 1'b1, 1'b0);
        send_char(i2 ? 8'h50 : 8'hC5, 1'b0, 1'b0);
    endtask

    task automatic restart_an();
        bus.an_enable = 1'b0;
        tick(2);
        check("an_enable_low_state", 32'(bus.an_state), 32'd0);
        bus.an_enable = 1'b1;
        tick(2);
    endtask

    // Full clean negotiation from ABILITY_DETECT to LINK_OK with word 0x01A0.
    task automatic negotiate(input string tag, input int exp_pcv);
        for (int i = 0; i < 3; i++) send_cfg(16'h01A0, 1'(i));
        tick(4);
        check({tag, "_ack_state"}, 32'(bus.an_state), 32'd2);
        check({tag, "_partner"}, 32'(bus.partner_cfg), 32'h01A0);
        check({tag, "_tx_ack"}, 32'(bus.tx_ack_req), 32'd1);
        for (int i = 0; i < 3; i++) send_cfg(16'h41A0, 1'(i));
        tick(4);
        check({tag, "_cack_state"}, 32'(bus.an_state), 32'd3);
        check({tag, "_cack_tx_ack"}, 32'(bus.tx_ack_req), 32'd1);
        tick(100);
        check({tag, "_idle_state"}, 32'(bus.an_state), 32'd4);
        check({tag, "_idle_tx_ack"}, 32'(bus.tx_ack_req), 32'd0);
        for (int i = 0; i < 5; i++) send_idle(1'(i));
        check({tag, "_idle_wait"}, 32'(bus.an_state), 32'd4);
        tick(100);
        check({tag, "_link_state"}, 32'(bus.an_state), 32'd5);
        check({tag, "_link_ok"}, 32'(bus.link_ok), 32'd1);
        check({tag, "_pcv_count"}, 32'(pcv_cnt), 32'(exp_pcv));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        pcv_cnt = 0;
        bus.an_enable   = 1'b0;
        bus.rx_valid    = 1'b0;
        bus.rx_data     = 8'h00;
        bus.rx_is_k     = 1'b0;
        bus.rx_code_err = 1'b0;
        rst_n = 1'b0;
        #12;
        check("rst_state", 32'(bus.an_state), 32'd0);
        check("rst_link_ok", 32'(bus.link_ok), 32'd0);
        check("rst_tx_ack", 32'(bus.tx_ack_req), 32'd0);
        check("rst_partner", 32'(bus.partner_cfg), 32'd0);
        check("rst_pcv", 32'(bus.partner_cfg_valid), 32'd0);
        check("rst_restart", 32'(bus.restart_pulse), 32'd0);
        rst_n = 1'b1;
        tick(2);
        check("disabled_hold", 32'(bus.an_state), 32'd0);
        bus.an_enable = 1'b1;
        tick(2);
        check("ability_entry", 32'(bus.an_state), 32'd1);

        // Clean negotiation
        send_cfg(16'h01A0, 1'b0);
        send_cfg(16'h01A0, 1'b1);
        tick(4);
        check("two_words_no_match", 32'(bus.an_state), 32'd1);
        send_cfg(16'h01A0, 1'b0);
        for (int i = 0; i < 2; i++) send_cfg(16'h01A0, 1'(i));
        tick(4);
        check("ability_match", 32'(bus.an_state), 32'd2);
        check("ability_partner", 32'(bus.partner_cfg), 32'h01A0);
        // Bring the ack phase through to LINK_OK
        for (int i = 0; i < 3; i++) send_cfg(16'h41A0, 1'(i));
        tick(4);
        check("clean_cack", 32'(bus.an_state), 32'd3);
        tick(100);
        check("clean_idle_detect", 32'(bus.an_state), 32'd4);
        check("clean_tx_ack_off", 32'(bus.tx_ack_req), 32'd0);
        for (int i = 0; i < 5; i++) send_idle(1'(i));
        tick(100);
        check("clean_link_state", 32'(bus.an_state), 32'd5);
        check("clean_link_ok", 32'(bus.link_ok), 32'd1);
        check("clean_pcv_once", 32'(pcv_cnt), 32'd1);

        // Break-link word in LINK_OK
        send_cfg(16'h0000, 1'b0);
        tick(1);
        check("brk_hold", 32'(bus.link_ok), 32'd1);
        tick(1);
        check("brk_state", 32'(bus.an_state), 32'd0);
        check("brk_link_drop", 32'(bus.link_ok), 32'd0);
        check("brk_restart", 32'(bus.restart_pulse), 32'd1);
        tick(1);
        check("brk_restart_1cyc", 32'(bus.restart_pulse), 32'd0);
        check("brk_ability", 32'(bus.an_state), 32'd1);
        negotiate("reneg", 2);

        // Alternating C1/C2 with a changing word
        restart_an();
        check("alt_link_off", 32'(bus.link_ok), 32'd0);
        send_cfg(16'h01A0, 1'b0);
        send_cfg(16'h01A0, 1'b1);
        send_cfg(16'h01A1, 1'b0);
        send_cfg(16'h01A1, 1'b1);
        tick(4);
        check("alt_no_match", 32'(bus.an_state), 32'd1);
        send_cfg(16'h01A1, 1'b0);
        tick(4);
        check("alt_match", 32'(bus.an_state), 32'd2);
        check("alt_partner", 32'(bus.partner_cfg), 32'h01A1);

        // Ack mismatch
        restart_an();
        for (int i = 0; i < 3; i++) send_cfg(16'h01A0, 1'(i));
        tick(4);
        check("ackmm_pre", 32'(bus.an_state), 32'd2);
        send_cfg(16'h41A1, 1'b0);
        tick(2);
        check("ackmm_state0", 32'(bus.an_state), 32'd0);
        check("ackmm_restart", 32'(bus.restart_pulse), 32'd1);
        tick(1);
        check("ackmm_state1", 32'(bus.an_state), 32'd1);
        send_cfg(16'h41A1, 1'b1);
        send_cfg(16'h41A1, 1'b0);
        tick(4);
        check("ackmm_stay", 32'(bus.an_state), 32'd1);
        check("ackmm_link", 32'(bus.link_ok), 32'd0);

        // Code error inside the second word
        restart_an();
        send_cfg(16'h01A0, 1'b0);
        send_char(8'hBC, 1'b1, 1'b0);
        send_char(8'hB5, 1'b0, 1'b0);
        send_char(8'hA0, 1'b0, 1'b1);
        send_char(8'h01, 1'b0, 1'b0);
        send_cfg(16'h01A0, 1'b1);
        send_cfg(16'h01A0, 1'b0);
        tick(4);
        check("err_two_clean", 32'(bus.an_state), 32'd1);
        send_cfg(16'h01A0, 1'b1);
        tick(4);
        check("err_three_clean", 32'(bus.an_state), 32'd2);

        // Asynchronous reset in COMPLETE_ACK
        for (int i = 0; i < 3; i++) send_cfg(16'h41A0, 1'(i));
        tick(20);
        check("ar_pre_state", 32'(bus.an_state), 32'd3);
        #3;
        rst_n = 1'b0;
        #1;
        check("ar_state", 32'(bus.an_state), 32'd0);
        check("ar_tx_ack", 32'(bus.tx_ack_req), 32'd0);
        check("ar_partner", 32'(bus.partner_cfg), 32'd0);
        check("ar_link", 32'(bus.link_ok), 32'd0);
        check("ar_pcv", 32'(bus.partner_cfg_valid), 32'd0);
        check("ar_restart", 32'(bus.restart_pulse), 32'd0);
        #2;
        rst_n = 1'b1;
        #1;
        check("ar_rel_state", 32'(bus.an_state), 32'd0);
        check("ar_rel_timer", 32'(dut.r_timer), 32'd0);
        @(posedge clk);
        #1;
        check("ar_rel_ability", 32'(bus.an_state), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/sgmii_an_rx_monitor.md
Name: sgmii_an_rx_monitor

Overview:
- Sits directly downstream of the SGMII deserializer/8b10b decoder on the receive side.
- Consumes decoded characters, parses /C1/ /C2/ configuration and /I1/ /I2/ idle ordered sets, and runs the receive side of SGMII auto-negotiation.
- Produces partner ability, an acknowledge request for the local transmitter, and link_ok.
- A link partner emitting /C/ ordered sets for a fixed number of repetitions, then idles, drives it to LINK_OK.

Parameters:
- MATCH_COUNT, 3: consecutive identical config words required for ability match and for ack match.
- IDLE_COUNT, 3: consecutive /I/ sets required in IDLE_DETECT.
- LINK_TIMER_CYCLES, 200000: link timer length in clock cycles (1.6 ms at 125 MHz).
- TIMER_W, 18: link timer counter width; must hold LINK_TIMER_CYCLES.

Ports:
- sgmii_clk_in, input, 1: 125 MHz character clock; all logic on the rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- an_enable, input, 1: 0 holds the FSM in AN_RESTART.
- rx_valid, input, 1: a decoded character is present this cycle.
- rx_data, input, 8: decoded character.
- rx_is_k, input, 1: the character is a K code.
- rx_code_err, input, 1: decoder code or disparity error on this character.
- an_state, output, 3: current FSM state encoding.
- partner_cfg, output, 16: latched partner config word.
- partner_cfg_valid, output, 1: one-cycle pulse when partner_cfg is updated.
- tx_ack_req, output, 1: the local transmitter must set the ack bit (bit 14).
- link_ok, output, 1: auto-negotiation is complete and the link is up.
- restart_pulse, output, 1: one-cycle pulse on every entry to AN_RESTART.

Behaviour:
- Reset values of all outputs are 0 and an_state is AN_RESTART. The parser and all counters clear.

Parser (advances only when rx_valid=1):
- K28.5 (0xBC, k=1) starts a set.
- The next character then classifies the set:
  - 0xB5 (D21.5) or 0x42 (D2.2), k=0: config set. The following two characters are cfg[7:0], then cfg[15:8].
  - 0xC5 (D5.6) or 0x50 (D16.2), k=0: idle set.
  - Anything else: invalid. The parser returns to hunt and the consecutive counters clear.
- rx_code_err=1 on any character aborts the current set. Treat it as invalid.
- K28.5 arriving mid-set restarts parsing at the new K28.5 and discards the partial set.
- cfg_word_valid (internal) pulses in the cycle after cfg[15:8] is accepted. idle_valid pulses in the cycle after the second idle character.

Match logic:
- ability_cnt counts consecutive config words equal to the previous word, comparing bits [15] and [13:0] (bit 14 ignored). A mismatch reloads it to 1. It saturates at MATCH_COUNT.
- ack_cnt is the same, but only words with bit14=1 count.
- An all-zero config word (a break-link set) clears both counters.
- idle_cnt counts consecutive idles. Any config word clears it.

FSM:
- AN_RESTART: clears counters and the timer. Go to ABILITY_DETECT on the next cycle if an_enable=1.
- ABILITY_DETECT: on ability_cnt reaching MATCH_COUNT with a nonzero word:
  - latch partner_cfg (bit14 masked to 0) and pulse partner_cfg_valid;
  - set tx_ack_req=1;
  - go to ACK_DETECT.
- ACK_DETECT:
  - ack_cnt reaching MATCH_COUNT with bits [15],[13:0] equal to partner_cfg goes to COMPLETE_ACK.
  - A mismatching word with bit14=1 goes to AN_RESTART.
  - A zero word goes to AN_RESTART.
- COMPLETE_ACK:
  - The timer counts from 0 and expires at LINK_TIMER_CYCLES-1, then goes to IDLE_DETECT.
  - A zero config word goes to AN_RESTART.
  - tx_ack_req stays 1.
- IDLE_DETECT:
  - tx_ack_req=0.
  - The timer restarts from 0.
  - Go to LINK_OK when idle_cnt>=IDLE_COUNT and the timer has expired.
  - Any config word goes to AN_RESTART.
- LINK_OK:
  - link_ok=1.
  - Any complete config set goes to AN_RESTART, with link_ok dropping the same cycle as the transition.
  - Idles and data keep the state.

Priority and edge cases:
- an_enable=0 forces AN_RESTART from any state and has the highest priority.
- The timer saturates at expiry and does not wrap.
- A reset assertion mid-sequence returns everything to reset values immediately (asynchronous).

State encoding: AN_RESTART=0, ABILITY_DETECT=1, ACK_DETECT=2, COMPLETE_ACK=3, IDLE_DETECT=4, LINK_OK=5.

Test Plan:
All scenarios use LINK_TIMER_CYCLES=100.
- Clean negotiation: 3x /C1/ with cfg 0x01A0, then 3x with cfg 0x41A0, then 5 idles after the timer → partner_cfg=0x01A0 with one partner_cfg_valid pulse, tx_ack_req high from ABILITY_DETECT exit until IDLE_DETECT, link_ok=1, an_state=5.
- Alternating C1/C2 delivery with a changing word (0x01A0, 0x01A0, 0x01A1, 0x01A1, 0x01A1) → ability match only after the third 0x01A1; partner_cfg=0x01A1.
- Ack mismatch: after ability match on 0x01A0, send 3x 0x41A1 → restart_pulse, an_state=0 then 1, link_ok=0.
- In LINK_OK, inject one /C1/ 0x0000 → link_ok drops and restart_pulse fires; renegotiation succeeds afterwards.
- rx_code_err on a cfg[7:0] character during the second of three words → ability_cnt clears; the match requires 3 further clean words.
- Drop reset_n asynchronously in COMPLETE_ACK → all outputs 0 immediately; an_state=0; the timer is cleared on release.
